// File: rtl/fifo_read_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and helpers for the FIFO read-port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, BURST)
//   *_DEF       : default values of the arbiter parameters
//   onehot()    : index -> one-hot vector, sized for the largest NREQ (8)
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int NREQ_DEF      = 4;
  localparam int DW_DEF        = 8;
  localparam int MAX_BURST_DEF = 4;
  localparam int NREQ_MAX      = 8;

  // Callers slice the low NREQ bits of the result.
  function automatic logic [NREQ_MAX-1:0] onehot(input logic [2:0] idx);
    logic [NREQ_MAX-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fifo_read_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_read_arbiter_if
// Bundle between the arbiter, the FIFO read side and the consumers.
//   req         : per-consumer level read request
//   rempty      : registered empty flag from the read gray counter
//   mem_rdata   : head word of the FIFO memory
//   read_enable : pop strobe to the read gray counter
//   grant       : one-hot current owner (0 when idle)
//   dout        : registered data bus shared by all consumers
//   dvalid      : one-hot qualifier telling which consumer owns dout
//   busy        : high while a burst is in progress
// Modports: master = arbiter side, slave = FIFO/consumer side.
// ---------------------------------------------------------------------------
interface fifo_read_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0] req;
  logic            rempty;
  logic [DW-1:0]   mem_rdata;
  logic            read_enable;
  logic [NREQ-1:0] grant;
  logic [DW-1:0]   dout;
  logic [NREQ-1:0] dvalid;
  logic            busy;

  modport master (
    input  req, rempty, mem_rdata,
    output read_enable, grant, dout, dvalid, busy
  );

  modport slave (
    output req, rempty, mem_rdata,
    input  read_enable, grant, dout, dvalid, busy
  );
endinterface

// File: rtl/fifo_read_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first requester strictly
// after i_last_owner, wrapping modulo NREQ (i_last_owner itself is checked
// last).
//   i_req        : request vector
//   i_last_owner : index of the most recent owner
//   o_pick       : chosen index (valid only when o_valid)
//   o_valid      : at least one request is present
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last_owner,
  output logic [IW-1:0]   o_pick,
  output logic            o_valid
);

  logic [IW-1:0] w_idx;

  // Scan from the farthest candidate to the nearest so the nearest
  // requester is the last assignment and therefore wins.
  always_comb begin
    o_pick  = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = IW'((int'(i_last_owner) + k) % NREQ);
      if (i_req[w_idx]) begin
        o_pick  = w_idx;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_read_arbiter
// Shares one async-FIFO read port between NREQ consumers. Grants round-robin,
// holds each grant for at most MAX_BURST pops, and returns popped words on a
// registered shared bus qualified by a one-hot dvalid.
//   clk : read-domain clock
//   rst : asynchronous active-high reset
//   bus : fifo_read_arbiter_if.master (req/rempty/mem_rdata in;
//         read_enable/grant/dout/dvalid/busy out)
// ---------------------------------------------------------------------------
module fifo_read_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ      = NREQ_DEF,
  parameter  int DW        = DW_DEF,
  parameter  int MAX_BURST = MAX_BURST_DEF,
  localparam int CW        = $clog2(MAX_BURST + 1),
  localparam int IW        = $clog2(NREQ)
) (
  input logic                clk,
  input logic                rst,
  fifo_read_arbiter_if.master bus
);

  arb_state_t      r_state;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_last_owner;
  logic [CW-1:0]   r_burst_cnt;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_dvalid;
  logic [DW-1:0]   r_dout;
  logic            r_busy;

  logic [IW-1:0]       w_pick;
  logic                w_pick_valid;
  logic                w_read_enable;
  logic                w_exit;
  logic [CW-1:0]       w_cnt_next;
  logic [NREQ_MAX-1:0] w_pick_oh;
  logic [NREQ_MAX-1:0] w_owner_oh;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .i_req        (bus.req),
    .i_last_owner (r_last_owner),
    .o_pick       (w_pick),
    .o_valid      (w_pick_valid)
  );

  assign w_pick_oh  = onehot(3'(w_pick));
  assign w_owner_oh = onehot(3'(r_owner));

  // Pop only for a still-requesting owner, with data present and burst
  // budget left; never while empty.
  assign w_read_enable = (r_state == BURST) && bus.req[r_owner] &&
                         !bus.rempty && (r_burst_cnt < CW'(MAX_BURST));

  // cnt < MAX_BURST whenever a pop happens, so the sum fits in CW bits.
  assign w_cnt_next = r_burst_cnt + CW'(w_read_enable);

  // Any exit condition (or several at once) ends the burst on this edge;
  // a pop in the same cycle still takes place.
  assign w_exit = !bus.req[r_owner] || bus.rempty ||
                  (w_cnt_next == CW'(MAX_BURST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_last_owner <= IW'(NREQ - 1);
      r_burst_cnt  <= '0;
      r_grant      <= '0;
      r_dvalid     <= '0;
      r_dout       <= '0;
      r_busy       <= 1'b0;
    end else begin
      // data return stage: word popped this cycle appears next cycle
      if (w_read_enable) begin
        r_dout   <= bus.mem_rdata;
        r_dvalid <= w_owner_oh[NREQ-1:0];
      end else begin
        r_dvalid <= '0;
      end

      // control stage
      case (r_state)
        IDLE: begin
          if (!bus.rempty && w_pick_valid) begin
            r_state     <= BURST;
            r_owner     <= w_pick;
            r_grant     <= w_pick_oh[NREQ-1:0];
            r_busy      <= 1'b1;
            r_burst_cnt <= '0;
          end
        end
        BURST: begin
          r_burst_cnt <= w_cnt_next;
          if (w_exit) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_busy       <= 1'b0;
            r_last_owner <= r_owner;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.read_enable = w_read_enable;
  assign bus.grant       = r_grant;
  assign bus.dout        = r_dout;
  assign bus.dvalid      = r_dvalid;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
module tb_fifo_read_arbiter;
  localparam int NREQ = 4, DW = 8, MAX_BURST = 4, DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_read_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();
  fifo_read_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // FIFO contents owned by the bench; the head word is what memory presents.
  logic [7:0]      fifo_q[$];
  logic [NREQ-1:0] req_drv;
  bit              pop_pend;

  // Behavioural model: who owns the port, how many words it has had.
  int m_owner, m_last, m_cnt, m_dvalid, m_dout;
  int m_popcnt[NREQ];

  int n_tests = 0, n_fail = 0;
  int lg_grant[$], lg_re[$], lg_dv[$], lg_dout[$];
  int iv_grant[$], iv_re[$], iv_gap[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = NREQ - 1; m_cnt = 0; m_dvalid = 0; m_dout = 0;
    for (int i = 0; i < NREQ; i++) m_popcnt[i] = 0;
  endtask

  task automatic clear_logs();
    lg_grant.delete(); lg_re.delete(); lg_dv.delete(); lg_dout.delete();
  endtask

  task automatic push(input int v);
    if (fifo_q.size() < DEPTH) fifo_q.push_back(v[7:0]);
  endtask

  // Drive inputs, compare outputs against the model, advance the model by
  // one clock, and return at the next falling edge.
  task automatic end_cycle();
    bit empty;
    int head, exp_re, exp_grant;
    empty = (fifo_q.size() == 0);
    head  = empty ? 0 : int'(fifo_q[0]);
    bus.req       = req_drv;
    bus.rempty    = empty;
    bus.mem_rdata = DW'(head);
    #1;
    exp_re = 0;
    if (m_owner >= 0)
      if (req_drv[m_owner] && !empty && m_cnt < MAX_BURST) exp_re = 1;
    exp_grant = (m_owner >= 0) ? (1 << m_owner) : 0;
    check("grant", bus.grant, exp_grant);
    check("busy", bus.busy, (m_owner >= 0) ? 1 : 0);
    check("dvalid", bus.dvalid, m_dvalid);
    check("dout", bus.dout, m_dout);
    check("read_enable", bus.read_enable, exp_re);
    lg_grant.push_back(int'(bus.grant));
    lg_re.push_back(int'(bus.read_enable));
    lg_dv.push_back(int'(bus.dvalid));
    lg_dout.push_back(int'(bus.dout));
    if (exp_re == 1) begin
      m_dout   = head;
      m_dvalid = 1 << m_owner;
      m_popcnt[m_owner]++;
      m_cnt++;
      pop_pend = 1'b1;
    end else begin
      m_dvalid = 0;
    end
    if (m_owner >= 0) begin
      if (!req_drv[m_owner] || empty || m_cnt == MAX_BURST) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end else if (!empty && req_drv != 0) begin
      for (int k = NREQ; k >= 1; k--)
        if (req_drv[(m_last + k) % NREQ]) m_owner = (m_last + k) % NREQ;
      m_cnt = 0;
    end
    @(negedge clk);
    if (pop_pend) begin
      void'(fifo_q.pop_front());
      pop_pend = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    fifo_q.delete();
    pop_pend = 1'b0;
    req_drv = '0;
    bus.req = '0; bus.rempty = 1'b1; bus.mem_rdata = '0;
    clear_logs();
    #1;
    check("rst_grant", bus.grant, 0);
    check("rst_dvalid", bus.dvalid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_re", bus.read_enable, 0);
    @(negedge clk);
    check("rst_dout", bus.dout, 0);
    rst = 1'b0;
  endtask

  // Split the logged run into grant intervals: owner, pops, idle gap before.
  function automatic void analyze();
    bit inside_iv = 0, seen = 0;
    int gap = 0;
    iv_grant.delete(); iv_re.delete(); iv_gap.delete();
    for (int i = 0; i < lg_grant.size(); i++) begin
      if (lg_grant[i] != 0) begin
        if (!inside_iv) begin
          if (seen) iv_gap.push_back(gap);
          inside_iv = 1; seen = 1;
          iv_grant.push_back(lg_grant[i]);
          iv_re.push_back(0);
        end
        if (lg_re[i] != 0) iv_re[iv_re.size()-1]++;
      end else begin
        if (inside_iv) begin inside_iv = 0; gap = 0; end
        gap++;
      end
    end
  endfunction

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int dv_pulses(input int b);
    int n = 0;
    foreach (lg_dv[i]) if (lg_dv[i][b]) n++;
    return n;
  endfunction

  function automatic int sum_re();
    int n = 0;
    foreach (lg_re[i]) n += lg_re[i];
    return n;
  endfunction

  initial begin
    int w;
    pop_pend = 1'b0;
    req_drv = '0;
    model_reset();
    @(negedge clk);

    // All consumers request after reset: consumer 0 first, then 1.
    do_reset();
    for (int i = 0; i < 16; i++) push(8'h10 + i);
    req_drv = 4'b1111;
    for (int c = 0; c < 14; c++) end_cycle();
    analyze();
    check("A_grant_c0", qget(lg_grant, 0), 0);
    check("A_grant_c1", qget(lg_grant, 1), 4'b0001);
    check("A_first_owner", qget(iv_grant, 0), 4'b0001);
    check("A_first_pops", qget(iv_re, 0), 4);
    check("A_dvalid0", dv_pulses(0), 4);
    check("A_gap", qget(iv_gap, 0), 1);
    check("A_second_owner", qget(iv_grant, 1), 4'b0010);

    // Sole requester with 10 words: bursts 4,4,2 and FIFO-order data.
    do_reset();
    for (int i = 0; i < 10; i++) push(8'hA0 + i);
    req_drv = 4'b0100;
    for (int c = 0; c < 20; c++) end_cycle();
    analyze();
    check("B_bursts", iv_re.size(), 3);
    check("B_burst0", qget(iv_re, 0), 4);
    check("B_burst1", qget(iv_re, 1), 4);
    check("B_burst2", qget(iv_re, 2), 2);
    check("B_gap0", qget(iv_gap, 0), 1);
    check("B_gap1", qget(iv_gap, 1), 1);
    check("B_dvalid2", dv_pulses(2), 10);
    w = 0;
    foreach (lg_dv[i]) if (lg_dv[i] != 0) begin
      check("B_dout_order", lg_dout[i], 8'hA0 + w);
      w++;
    end

    // Consumer 1 drops its request after two pops.
    do_reset();
    for (int i = 0; i < 12; i++) push(8'h30 + i);
    req_drv = 4'b0110;
    for (int c = 0; c < 20; c++) begin
      if (m_popcnt[1] >= 2) req_drv[1] = 1'b0;
      end_cycle();
    end
    analyze();
    check("C_first_owner", qget(iv_grant, 0), 4'b0010);
    check("C_first_pops", qget(iv_re, 0), 2);
    check("C_dvalid1", dv_pulses(1), 2);
    check("C_next_owner", qget(iv_grant, 1), 4'b0100);

    // Empty FIFO holds everything idle until data arrives.
    do_reset();
    req_drv = 4'b0101;
    for (int c = 0; c < 6; c++) end_cycle();
    analyze();
    check("D_no_grant", iv_grant.size(), 0);
    check("D_no_re", sum_re(), 0);
    for (int i = 0; i < 3; i++) push(8'h55 + i);
    end_cycle();
    end_cycle();
    check("D_grant_after_fill", qget(lg_grant, 7), 4'b0001);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    for (int i = 0; i < 16; i++) push(8'hC0 + i);
    req_drv = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      if (m_owner == 0 && m_cnt == 2) break;
      end_cycle();
    end
    check("E_reached_cnt2", m_cnt, 2);
    #2;
    rst = 1'b1;
    #1;
    check("E_grant", bus.grant, 0);
    check("E_dvalid", bus.dvalid, 0);
    check("E_busy", bus.busy, 0);
    check("E_re", bus.read_enable, 0);
    model_reset();
    pop_pend = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    end_cycle();
    end_cycle();
    check("E_restart_owner", qget(lg_grant, 1), 4'b0001);

    // Fourth pop coincides with the budget end; FIFO empties and req drops.
    do_reset();
    for (int i = 0; i < 4; i++) push(8'hE0 + i);
    req_drv = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      if (m_popcnt[0] >= 4) req_drv = '0;
      end_cycle();
    end
    analyze();
    check("F_re_total", sum_re(), 4);
    check("F_dvalid0", dv_pulses(0), 4);
    check("F_bursts", iv_grant.size(), 1);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req_drv = NREQ'($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 0) push(int'($urandom_range(0, 255)));
      if ($urandom_range(0, 9) == 0) push(int'($urandom_range(0, 255)));
      end_cycle();
      check("R_dvalid_onehot", ($countones(bus.dvalid) <= 1) ? 1 : 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
